micro_alpha_veryl_mux_buf: RTL
==============================

Name: micro_alpha_veryl_mux_buf

Overview:
Parametrised N:1 word selector with a registered, handshaked output stage. It is the successor to the combinational 2:1 datapath mux.
- Captures din[selector] on a valid/ready input handshake.
- Holds results in a 2-entry in-order output buffer.
- Presents results on a valid/ready output handshake.
- Used in the ALU/writeback path where operand or result selection must be pipelined and back-pressured without stalling the producer when the buffer has space.

Parameters:
NUM_INPUTS, 2, number of selectable input words; legal range 2..16.
WIDTH, 32, bit width of each input word and of dout.
SEL_WIDTH, 1, selector width; must be >= clog2(NUM_INPUTS). Selector values >= NUM_INPUTS are out of range.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
in_valid  input  1  selector/din valid this cycle.
in_ready  output  1  block can accept a word this cycle.
selector  input  SEL_WIDTH  index of the input word to capture.
din  input  WIDTH x NUM_INPUTS  unpacked array din[0:NUM_INPUTS-1] of candidate words.
out_valid  output  1  buffer head is valid.
out_ready  input  1  consumer accepts the head this cycle.
dout  output  WIDTH  buffer-head data.
out_sel  output  SEL_WIDTH  selector value captured with the head entry.

Behaviour:
- Clocking and reset: one clock (clk); reset rst_n is synchronous, active-low.
- State:
  - 2-entry buffer, each entry {data[WIDTH], sel[SEL_WIDTH]}.
  - Read pointer rp and write pointer wp, 1 bit each.
  - count register, 0..2.
- Reset (rst_n=0 at a clk edge):
  - count=0, rp=wp=0, all entry data/sel cleared to 0.
  - out_valid=0, dout=0, out_sel=0.
- While rst_n is low, in_ready is driven 0 combinationally and no push is recorded.
- Reset mid-operation discards all buffered entries. No output handshake completes in the cycle rst_n is low.
- Handshake signals:
  - in_ready = rst_n and (count != 2). It depends only on state and rst_n; no combinational path from out_ready.
  - push = in_valid and in_ready.
  - pop = out_valid and out_ready.
  - out_valid = (count != 0).
  - dout and out_sel come directly from entry[rp]. When count==0: dout=0, out_sel=0.
- Capture on push:
  - entry[wp].data <= din[selector] if selector < NUM_INPUTS, else all-zero.
  - entry[wp].sel <= selector; wp toggles.
- Pop: rp toggles.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together (only possible at count==1): count stays 1; the new word becomes the head on the next cycle.
- Latency: a word pushed at edge t into an empty buffer has out_valid=1 and dout valid after edge t, i.e. one cycle of latency.
- Throughput: one word per cycle sustained while out_ready stays high.
- Order: strictly FIFO. Data and selector are held stable while out_valid=1 and out_ready=0.
- Full (count==2): in_ready=0; in_valid is ignored; din and selector may change freely.
- Empty (count==0): out_ready is ignored.
- Inputs are sampled only at push; changes to din after the push do not affect buffered data.

Optional Feature:
Macro MICRO_ALPHA_VERYL_MUX_SEL_ERR_EN.
- Defined:
  - Adds output out_sel_err (1 bit), stored per entry.
  - out_sel_err = 1 when the head entry was captured with selector >= NUM_INPUTS.
  - Reset value 0; forced 0 when count==0.
- Not defined:
  - Port is absent.
  - Out-of-range selections still produce data 0, silently.

Test Plan:
1. Reset with in_valid=1, then release. Required: in_ready=0 and out_valid=0 during reset; dout=0; in_ready=1 on the first cycle after release.
2. NUM_INPUTS=4, WIDTH=32, din={32'h0000A5A5, 32'h00005A5A, 32'hDEADBEEF, 32'h12345678}, selector=2, push with out_ready=1. Required: next cycle out_valid=1, dout=32'hDEADBEEF, out_sel=2.
3. Hold out_ready=0 and push three words (selector 0, 1, 3). Required: count reaches 2 and in_ready=0 after the second push; the third word is not accepted. Then out_ready=1. Required: dout sequence 32'h0000A5A5 then 32'h00005A5A, then out_valid=0.
4. With one entry buffered, push and pop in the same cycle. Required: count stays 1 and the next dout is the newly pushed word. With in_valid=1 and out_ready=1 held for 8 cycles: 8 words out, in order, with no bubble.
5. NUM_INPUTS=3, SEL_WIDTH=2, selector=3. Required: dout=0 and out_sel=3; out_sel_err=1 when MICRO_ALPHA_VERYL_MUX_SEL_ERR_EN is defined.
6. With 2 entries buffered, assert rst_n=0 for one cycle. Required: out_valid=0 and dout=0 on the next cycle, and no stale data appears afterward.

Source files
------------

// File: rtl/micro_alpha_veryl_mux_buf.sv
// N:1 word selector feeding a 2-entry in-order buffer with valid/ready on both sides.
// Optional MICRO_ALPHA_VERYL_MUX_SEL_ERR_EN adds out_sel_err for out-of-range selections.
module micro_alpha_veryl_mux_buf #(
    parameter int unsigned NUM_INPUTS = 2,
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned SEL_WIDTH  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SEL_WIDTH-1:0] selector,
    input  logic [WIDTH-1:0]     din [NUM_INPUTS],
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     dout,
`ifdef MICRO_ALPHA_VERYL_MUX_SEL_ERR_EN
    output logic                 out_sel_err,
`endif
    output logic [SEL_WIDTH-1:0] out_sel
);

    localparam int unsigned DEPTH   = 2;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned EXT_W   = 32;

    logic [WIDTH-1:0]     data_q [DEPTH];
    logic [SEL_WIDTH-1:0] sel_q  [DEPTH];
    logic                 rp;
    logic                 wp;
    logic [CNT_W-1:0]     count;

    logic                 push;
    logic                 pop;
    logic [EXT_W-1:0]     sel_ext;
    logic [WIDTH-1:0]     din_sel;

    assign in_ready  = rst_n && (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = rst_n && out_valid && out_ready;
    assign sel_ext   = EXT_W'(selector);

    // Out-of-range selectors match no candidate and fall through to zero.
    always_comb begin
        din_sel = '0;
        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            if (sel_ext == EXT_W'(i)) begin
                din_sel = din[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                sel_q[i]  <= '0;
            end
            rp    <= 1'b0;
            wp    <= 1'b0;
            count <= '0;
        end else begin
            if (push) begin
                data_q[wp] <= din_sel;
                sel_q[wp]  <= selector;
                wp         <= ~wp;
            end
            if (pop) begin
                rp <= ~rp;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Head is gated so a drained buffer never exposes stale entries.
    assign dout    = out_valid ? data_q[rp] : '0;
    assign out_sel = out_valid ? sel_q[rp]  : '0;

`ifdef MICRO_ALPHA_VERYL_MUX_SEL_ERR_EN
    logic [DEPTH-1:0] err_q;
    logic             sel_err;

    assign sel_err = (sel_ext >= EXT_W'(NUM_INPUTS));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= '0;
        end else if (push) begin
            err_q[wp] <= sel_err;
        end
    end

    assign out_sel_err = out_valid && err_q[rp];
`endif

endmodule
